// File: rtl/dps_decoder_16.sv
// dps_decoder_16: two-stage pipelined decoder for the 16-bit DPS code.
// Fibonacci-weighted bit sum with valid/ready flow control and full backpressure.
module dps_decoder_16 #(
    parameter int DATA_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       codein,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready
);

    // Per-bit weights: 1, then F2..F14, then 2*F15 and F16.
    localparam logic [11:0] WEIGHT [16] = '{
        12'd1,   12'd1,   12'd2,   12'd3,
        12'd5,   12'd8,   12'd13,  12'd21,
        12'd34,  12'd55,  12'd89,  12'd144,
        12'd233, 12'd377, 12'd1220, 12'd987
    };

    logic        s1_valid;
    logic [11:0] p_q    [4];
    logic [11:0] p_next [4];
    logic [11:0] total;
    logic        adv1;
    logic        adv2;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign total    = p_q[0] + p_q[1] + p_q[2] + p_q[3];

    // Four nibble-wide partial sums of the incoming codeword.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            p_next[g] = '0;
            for (int b = 0; b < 4; b++) begin
                if (codein[4*g+b]) begin
                    p_next[g] = p_next[g] + WEIGHT[4*g+b];
                end
            end
        end
    end

    // Stage 1: capture partial sums when the stage can advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            for (int g = 0; g < 4; g++) begin
                p_q[g] <= '0;
            end
        end else if (adv1) begin
            s1_valid <= in_valid;
            for (int g = 0; g < 4; g++) begin
                p_q[g] <= p_next[g];
            end
        end
    end

    // Stage 2: final sum, held stable until downstream consumes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            dataout   <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            dataout   <= DATA_W'(total);
        end
    end

endmodule
